// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and data requesters
// Optional macro MEM_ARB_RR_EN selects round-robin grant on contention.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  output logic                    i_ready_o,
  input  logic                    d_read_i,
  input  logic                    d_write_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_ready_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i,
  output logic                    proto_err_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  i_valid;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  d_valid;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [STRB_WIDTH-1:0] d_wstrb;

  logic handshake;
  logic i_accept;
  logic d_pulse;
  logic d_conflict;
  logic d_accept;
  logic err_now;
  logic grant_d;

  // A slot being valid is exactly the requester's busy window, so it gates new pulses.
  assign handshake  = mem_req_o & mem_ready_i;
  assign i_accept   = i_req_i & ~i_valid;
  assign d_pulse    = d_read_i | d_write_i;
  assign d_conflict = d_read_i & d_write_i;
  assign d_accept   = d_pulse & ~d_conflict & ~d_valid;
  assign err_now    = (i_req_i & i_valid) | (d_pulse & d_valid) | d_conflict;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (handshake) begin
      last_d <= (state == BUSY_D);
    end
  end

  assign grant_d = d_valid & (~i_valid | ~last_d);
`else
  assign grant_d = d_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid <= 1'b0;
      i_addr  <= '0;
    end else if (i_accept) begin
      i_valid <= 1'b1;
      i_addr  <= i_addr_i;
    end else if (handshake && state == BUSY_I) begin
      i_valid <= 1'b0;
    end
  end

  // Strobes and write data are stored masked so loads present all-zero strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_we    <= 1'b0;
      d_addr  <= '0;
      d_wdata <= '0;
      d_wstrb <= '0;
    end else if (d_accept) begin
      d_valid <= 1'b1;
      d_we    <= d_write_i;
      d_addr  <= d_addr_i;
      d_wdata <= d_write_i ? d_wdata_i : '0;
      d_wstrb <= d_write_i ? d_wstrb_i : '0;
    end else if (handshake && state == BUSY_D) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_o <= 1'b0;
    end else if (err_now) begin
      proto_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ready_o <= 1'b0;
      d_ready_o <= 1'b0;
      i_rdata_o <= '0;
      d_rdata_o <= '0;
    end else begin
      i_ready_o <= handshake && (state == BUSY_I);
      d_ready_o <= handshake && (state == BUSY_D);
      if (handshake && state == BUSY_I) begin
        i_rdata_o <= mem_rdata_i;
      end
      if (handshake && state == BUSY_D && !d_we) begin
        d_rdata_o <= mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_valid || i_valid) begin
          state_next = grant_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I: begin
        if (mem_ready_i) begin
          state_next = d_valid ? BUSY_D : IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready_i) begin
          state_next = i_valid ? BUSY_I : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory fields come straight from the owning slot, which is frozen while it is busy.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    case (state)
      BUSY_I: begin
        mem_req_o  = 1'b1;
        mem_addr_o = i_addr;
      end
      BUSY_D: begin
        mem_req_o   = 1'b1;
        mem_we_o    = d_we;
        mem_addr_o  = d_addr;
        mem_wdata_o = d_wdata;
        mem_wstrb_o = d_wstrb;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_rdata_o;
  logic        i_ready_o;
  logic        d_read_i;
  logic        d_write_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_wstrb_i;
  logic [31:0] d_rdata_o;
  logic        d_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        proto_err_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] first_addr;
  logic [31:0] second_addr;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_rdata_o   (i_rdata_o),
    .i_ready_o   (i_ready_o),
    .d_read_i    (d_read_i),
    .d_write_i   (d_write_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_wstrb_i   (d_wstrb_i),
    .d_rdata_o   (d_rdata_o),
    .d_ready_o   (d_ready_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    i_req_i = 1'b0; i_addr_i = '0;
    d_read_i = 1'b0; d_write_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
    mem_rdata_i = '0; mem_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb_o, 4'h0);
    chk("rst_i_ready", i_ready_o, 1'b0);
    chk("rst_d_ready", d_ready_o, 1'b0);
    chk("rst_i_rdata", i_rdata_o, 32'h0);
    chk("rst_d_rdata", d_rdata_o, 32'h0);
    chk("rst_proto_err", proto_err_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Zero-wait fetch: pulse T, request T+2, ready T+3
    i_req_i = 1'b1; i_addr_i = 32'h100; mem_rdata_i = 32'h00500093;
    tick();
    i_req_i = 1'b0; i_addr_i = 32'h0;
    chk("f_t1_req", mem_req_o, 1'b0);
    tick();
    chk("f_t2_req", mem_req_o, 1'b1);
    chk("f_t2_addr", mem_addr_o, 32'h100);
    chk("f_t2_we", mem_we_o, 1'b0);
    chk("f_t2_wstrb", mem_wstrb_o, 4'h0);
    chk("f_t2_ready", i_ready_o, 1'b0);
    tick();
    chk("f_t3_ready", i_ready_o, 1'b1);
    chk("f_t3_rdata", i_rdata_o, 32'h00500093);
    chk("f_t3_req", mem_req_o, 1'b0);
    tick();
    chk("f_t4_ready", i_ready_o, 1'b0);
    chk("f_t4_rdata_hold", i_rdata_o, 32'h00500093);

    // Store with three stall cycles
    mem_ready_i = 1'b0; mem_rdata_i = 32'hCAFEF00D;
    d_write_i = 1'b1; d_addr_i = 32'h2004; d_wdata_i = 32'hDEADBEEF; d_wstrb_i = 4'h3;
    tick();
    d_write_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0; d_wstrb_i = 4'h0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("st_req", mem_req_o, 1'b1);
      chk("st_we", mem_we_o, 1'b1);
      chk("st_addr", mem_addr_o, 32'h2004);
      chk("st_wdata", mem_wdata_o, 32'hDEADBEEF);
      chk("st_wstrb", mem_wstrb_o, 4'h3);
      chk("st_no_ready", d_ready_o, 1'b0);
      if (k == 3) mem_ready_i = 1'b1;
      tick();
    end
    chk("st_ready", d_ready_o, 1'b1);
    chk("st_rdata_unchanged", d_rdata_o, 32'h0);
    chk("st_idle", mem_req_o, 1'b0);
    tick();
    chk("st_ready_width", d_ready_o, 1'b0);

    // Simultaneous fetch + load: data first, fetch next cycle
    i_req_i = 1'b1; i_addr_i = 32'h100; d_read_i = 1'b1; d_addr_i = 32'h2000;
    tick();
    i_req_i = 1'b0; d_read_i = 1'b0;
    tick();
    chk("sim_first_addr", mem_addr_o, 32'h2000);
    chk("sim_first_we", mem_we_o, 1'b0);
    chk("sim_first_wstrb", mem_wstrb_o, 4'h0);
    mem_rdata_i = 32'h11111111;
    tick();
    chk("sim_second_req", mem_req_o, 1'b1);
    chk("sim_second_addr", mem_addr_o, 32'h100);
    chk("sim_d_ready", d_ready_o, 1'b1);
    chk("sim_d_rdata", d_rdata_o, 32'h11111111);
    chk("sim_i_not_yet", i_ready_o, 1'b0);
    mem_rdata_i = 32'h22222222;
    tick();
    chk("sim_i_ready", i_ready_o, 1'b1);
    chk("sim_i_rdata", i_rdata_o, 32'h22222222);
    chk("sim_d_ready_off", d_ready_o, 1'b0);
    chk("sim_d_rdata_hold", d_rdata_o, 32'h11111111);
    chk("sim_idle", mem_req_o, 1'b0);

    // Lone load leaves data as last grant; next contention order depends on build
    d_read_i = 1'b1; d_addr_i = 32'h3000;
    tick();
    d_read_i = 1'b0;
    tick();
    chk("solo_addr", mem_addr_o, 32'h3000);
    tick();
    tick();
    i_req_i = 1'b1; i_addr_i = 32'h100; d_read_i = 1'b1; d_addr_i = 32'h2000;
`ifdef MEM_ARB_RR_EN
    first_addr = 32'h100; second_addr = 32'h2000;
`else
    first_addr = 32'h2000; second_addr = 32'h100;
`endif
    tick();
    i_req_i = 1'b0; d_read_i = 1'b0;
    tick();
    chk("arb_first", mem_addr_o, first_addr);
    tick();
    chk("arb_second", mem_addr_o, second_addr);
    tick();
    chk("arb_done", mem_req_o, 1'b0);

    // Re-pulse during a stalled fetch is dropped and flagged
    chk("pe_clear", proto_err_o, 1'b0);
    mem_ready_i = 1'b0; mem_rdata_i = 32'h33333333;
    i_req_i = 1'b1; i_addr_i = 32'h100;
    tick();
    i_req_i = 1'b0;
    tick();
    i_req_i = 1'b1; i_addr_i = 32'h500;
    tick();
    i_req_i = 1'b0;
    chk("pe_set", proto_err_o, 1'b1);
    chk("pe_addr_stable", mem_addr_o, 32'h100);
    chk("pe_no_ready", i_ready_o, 1'b0);
    mem_ready_i = 1'b1;
    tick();
    chk("pe_ready", i_ready_o, 1'b1);
    chk("pe_rdata", i_rdata_o, 32'h33333333);
    tick();
    chk("pe_one_ready_a", i_ready_o, 1'b0);
    chk("pe_no_replay_a", mem_req_o, 1'b0);
    tick();
    chk("pe_one_ready_b", i_ready_o, 1'b0);
    chk("pe_no_replay_b", mem_req_o, 1'b0);
    chk("pe_sticky", proto_err_o, 1'b1);

    // Reset during a stalled load aborts it
    mem_ready_i = 1'b0;
    d_read_i = 1'b1; d_addr_i = 32'h2000;
    tick();
    d_read_i = 1'b0;
    tick();
    chk("ra_busy", mem_req_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("ra_req_async", mem_req_o, 1'b0);
    chk("ra_addr", mem_addr_o, 32'h0);
    tick();
    rst_n = 1'b1; mem_ready_i = 1'b1;
    chk("ra_err_clear", proto_err_o, 1'b0);
    chk("ra_rdata_clear", d_rdata_o, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ra_no_ready", d_ready_o, 1'b0);
      chk("ra_idle", mem_req_o, 1'b0);
    end

    // New pulse in the ready cycle is legal
    mem_rdata_i = 32'hAAAA0001;
    i_req_i = 1'b1; i_addr_i = 32'h100;
    tick();
    i_req_i = 1'b0;
    tick();
    tick();
    chk("rp_ready", i_ready_o, 1'b1);
    i_req_i = 1'b1; i_addr_i = 32'h104; mem_rdata_i = 32'hAAAA0002;
    tick();
    i_req_i = 1'b0;
    chk("rp_no_err", proto_err_o, 1'b0);
    chk("rp_ready_off", i_ready_o, 1'b0);
    tick();
    chk("rp_req", mem_req_o, 1'b1);
    chk("rp_addr", mem_addr_o, 32'h104);
    tick();
    chk("rp_ready2", i_ready_o, 1'b1);
    chk("rp_rdata2", i_rdata_o, 32'hAAAA0002);

    // Same-cycle load and store is dropped
    d_read_i = 1'b1; d_write_i = 1'b1; d_addr_i = 32'h2008; d_wdata_i = 32'h12345678; d_wstrb_i = 4'hF;
    tick();
    d_read_i = 1'b0; d_write_i = 1'b0;
    chk("cf_err", proto_err_o, 1'b1);
    tick();
    chk("cf_no_req_a", mem_req_o, 1'b0);
    tick();
    chk("cf_no_req_b", mem_req_o, 1'b0);
    chk("cf_no_ready", d_ready_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
